// File: rtl/dfp_pkg.sv
// Shared definitions for the DFPlayer command scheduler: frame constants,
// command codes, FSM state encoding and the frame checksum helper.
package dfp_pkg;

  localparam logic [7:0] START = 8'h7E;
  localparam logic [7:0] VER   = 8'hFF;
  localparam logic [7:0] LEN   = 8'h06;
  localparam logic [7:0] END   = 8'hEF;

  localparam logic [7:0] NEXT  = 8'h01;
  localparam logic [7:0] PREV  = 8'h02;
  localparam logic [7:0] PLAY  = 8'h03;
  localparam logic [7:0] VOL   = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SEND,
    ACK,
    DONE,
    GAP
  } state_t;

  // Two's-complement of the byte sum from VER through the parameter low byte.
  function automatic logic [15:0] dfp_checksum(input logic [7:0]  cmd,
                                               input logic [7:0]  fb,
                                               input logic [15:0] param);
    logic [15:0] sum;
    sum = {8'h00, VER} + {8'h00, LEN} + {8'h00, cmd} + {8'h00, fb}
        + {8'h00, param[15:8]} + {8'h00, param[7:0]};
    return 16'h0000 - sum;
  endfunction

endpackage

// File: rtl/dfp_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward,
// wrapping modulo NREQ, and returns a one-hot grant (all zero when disabled).
module dfp_rr_arbiter
  import dfp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LGW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LGW-1:0]  last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  logic [LGW-1:0] pos;
  logic           found;

  // Rotate the search origin and pick the first active requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = last_grant;
    for (int i = 0; i < NREQ; i++) begin
      pos = (pos == LGW'(NREQ - 1)) ? '0 : pos + LGW'(1);
      if (enable && !found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfp_cmd_scheduler.sv
// DFPlayer command scheduler: round-robin arbitration between requesters,
// frame assembly and byte-wise hand-off to uart_tx, followed by an
// inter-command gap. Build option DFP_CHECKSUM_EN selects the 10-byte
// frame with checksum; otherwise the 8-byte frame without checksum.
module dfp_cmd_scheduler
  import dfp_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int FEEDBACK   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_cmd,
  input  logic [NREQ*16-1:0] req_param,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              frame_done
);

  localparam int LGW = $clog2(NREQ);
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0] FB = 8'(FEEDBACK);
`ifdef DFP_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  state_t          state, state_d;
  logic [NREQ-1:0] grant_d, arb_grant;
  logic [7:0]      tx_data_d;
  logic            tx_start_d, frame_done_d, latch;
  logic [3:0]      idx, idx_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [LGW-1:0]  last_grant, last_d, sel_idx;
  logic [7:0]      sel_cmd, cmd_q, cur_byte;
  logic [15:0]     sel_param, param_q;
`ifdef DFP_CHECKSUM_EN
  logic [15:0]     chk_q;
`endif

  dfp_rr_arbiter #(.NREQ(NREQ), .LGW(LGW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (arb_grant)
  );

  assign busy = (state != IDLE);

  // Encode the winning requester and select its command and parameter.
  always_comb begin
    sel_idx   = '0;
    sel_cmd   = '0;
    sel_param = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_idx   = LGW'(i);
        sel_cmd   = req_cmd[i*8 +: 8];
        sel_param = req_param[i*16 +: 16];
      end
    end
  end

  // Frame byte addressed by the current byte index.
  always_comb begin
    cur_byte = END;
    case (idx)
      4'd0:    cur_byte = START;
      4'd1:    cur_byte = VER;
      4'd2:    cur_byte = LEN;
      4'd3:    cur_byte = cmd_q;
      4'd4:    cur_byte = FB;
      4'd5:    cur_byte = param_q[15:8];
      4'd6:    cur_byte = param_q[7:0];
`ifdef DFP_CHECKSUM_EN
      4'd7:    cur_byte = chk_q[15:8];
      4'd8:    cur_byte = chk_q[7:0];
`endif
      default: cur_byte = END;
    endcase
  end

  // Command latch: captured once at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch) begin
      cmd_q   <= sel_cmd;
      param_q <= sel_param;
`ifdef DFP_CHECKSUM_EN
      chk_q   <= dfp_checksum(sel_cmd, FB, sel_param);
`endif
    end
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d      = state;
    grant_d      = '0;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    idx_d        = idx;
    gap_d        = gap_cnt;
    last_d       = last_grant;
    latch        = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_grant) begin
          grant_d = arb_grant;
          last_d  = sel_idx;
          latch   = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The first byte goes out straight from here when the UART is free.
        idx_d = '0;
        if (!tx_busy) begin
          tx_data_d  = START;
          tx_start_d = 1'b1;
          state_d    = ACK;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (tx_busy) state_d = DONE;
      end
      DONE: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            idx_d        = '0;
            gap_d        = '0;
            frame_done_d = 1'b1;
            state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_d   = idx + 4'd1;
            state_d = SEND;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
        else                     gap_d   = gap_cnt + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      idx        <= '0;
      gap_cnt    <= '0;
      last_grant <= LGW'(NREQ - 1);
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      frame_done <= frame_done_d;
      idx        <= idx_d;
      gap_cnt    <= gap_d;
      last_grant <= last_d;
    end
  end

endmodule

// File: tb/tb_dfp_cmd_scheduler.sv
// Directed bench for dfp_cmd_scheduler with a simple uart_tx busy model.
`timescale 1ns/1ps
module tb_dfp_cmd_scheduler;

  localparam int NREQ  = 4;
  localparam int GAP   = 20;
  localparam int LIMIT = 3000;
`ifdef DFP_CHECKSUM_EN
  localparam int NB = 10;
  logic [7:0] exp_a [NB] = '{8'h7E, 8'hFF, 8'h06, 8'h03, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hF7, 8'hEF};
  logic [7:0] exp_b [NB] = '{8'h7E, 8'hFF, 8'h06, 8'h06, 8'h00, 8'h00, 8'h0F, 8'hFE, 8'hE6, 8'hEF};
`else
  localparam int NB = 8;
  logic [7:0] exp_a [NB] = '{8'h7E, 8'hFF, 8'h06, 8'h03, 8'h00, 8'h00, 8'h01, 8'hEF};
  logic [7:0] exp_b [NB] = '{8'h7E, 8'hFF, 8'h06, 8'h06, 8'h00, 8'h00, 8'h0F, 8'hEF};
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_cmd;
  logic [NREQ*16-1:0] req_param;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic              busy;
  logic              frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // uart_tx model state
  logic [7:0] cap_q [$];
  int         st_q [$];
  int         cyc = 0;
  int         bcnt = 0;
  int         stall_at = -1;
  int         n_viol = 0, n_dbl = 0, n_stab = 0, n_fd = 0;
  bit         armed = 1'b0, stab_en = 1'b0;
  logic [7:0] last_byte = 8'h00;

  dfp_cmd_scheduler #(.NREQ(NREQ), .GAP_CYCLES(GAP), .FEEDBACK(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_cmd    (req_cmd),
    .req_param  (req_param),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy one cycle after start, for 5 cycles (100 when stalled).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) n_fd <= n_fd + 1;
    if (tx_busy) armed <= 1'b0;
    if (reset) stab_en <= 1'b0;
    else if (stab_en && tx_busy && tx_data != last_byte) n_stab <= n_stab + 1;
    if (tx_start) begin
      if (tx_busy) n_viol <= n_viol + 1;
      if (armed) n_dbl <= n_dbl + 1;
      armed     <= 1'b1;
      bcnt      <= (cap_q.size() == stall_at) ? 100 : 5;
      cap_q.push_back(tx_data);
      st_q.push_back(cyc);
      last_byte <= tx_data;
      stab_en   <= 1'b1;
      tx_busy   <= 1'b1;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      bcnt    <= 0;
      tx_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output int n);
    g = '0;
    n = 0;
    while (n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      if (grant != '0) begin
        g = grant;
        return;
      end
    end
    check("grant_timeout", 0, 1);
  endtask

  task automatic wait_fd();
    for (int k = 0; k < LIMIT; k++) begin
      @(posedge clk); #1;
      if (frame_done) return;
    end
    check("frame_done_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input int base, input bit use_b);
    logic [7:0] got;
    check({tag, "_nbytes"}, cap_q.size() - base, NB);
    for (int i = 0; i < NB; i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 8'h00;
      check($sformatf("%s_b%0d", tag, i), got, use_b ? exp_b[i] : exp_a[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [NREQ-1:0] g;
  int n, base, fd0, gcount;

  initial begin
    req_cmd   = {8'h02, 8'h01, 8'h06, 8'h03};
    req_param = {16'h0000, 16'h0002, 16'h000F, 16'h0001};
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // single requester 0: PLAY 0001, latency and frame bytes
    base = cap_q.size();
    fd0  = n_fd;
    req  = 4'b0001;
    wait_grant(g, n);
    check("t1_grant", g, 4'b0001);
    check("t1_grant_lat", n, 1);
    req = '0;
    req_cmd[7:0]    = 8'hAA;
    req_param[15:0] = 16'h5555;
    @(posedge clk); #1;
    check("t1_first_start", tx_start, 1);
    check("t1_first_data", tx_data, 8'h7E);
    check("t1_grant_pulse", grant, 0);
    wait_fd();
    @(posedge clk); #1;
    check("t1_fd_pulse", frame_done, 0);
    check("t1_busy_in_gap", busy, 1);
    check("t1_fd_count", n_fd - fd0, 1);
    check_frame("t1", base, 1'b0);
    req_cmd[7:0]    = 8'h03;
    req_param[15:0] = 16'h0001;

    // requester 1: VOL 000F, requested during gap
    base = cap_q.size();
    req  = 4'b0010;
    wait_grant(g, n);
    check("t2_grant", g, 4'b0010);
    req = '0;
    wait_fd();
    check_frame("t2", base, 1'b1);

    // simultaneous req0 and req2: one grant, then the other after the gap
    do_reset();
    req = 4'b0101;
    wait_grant(g, n);
    check("t3_grant_a", g, 4'b0001);
    req = 4'b0100;
    wait_fd();
    wait_grant(g, n);
    check("t3_grant_b", g, 4'b0100);
    check("t3_gap_lat", n, GAP + 1);
    req = '0;
    wait_fd();

    // all requesters held: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, n);
      check($sformatf("t4_grant%0d", k), g, 4'b0001 << (k % 4));
    end
    req = '0;
    wait_fd();

    // UART stall on first byte, then req pulse during gap
    do_reset();
    base     = cap_q.size();
    stall_at = base;
    req      = 4'b0001;
    wait_grant(g, n);
    req = '0;
    wait_fd();
    stall_at = -1;
    check("t5_stall_quiet", (st_q.size() > base + 1) && (st_q[base + 1] - st_q[base] > 100), 1);
    check_frame("t5", base, 1'b0);
    @(posedge clk); #1;
    req = 4'b0010;
    @(posedge clk); #1;
    req = '0;
    gcount = 0;
    for (int k = 0; k < GAP; k++) begin
      @(posedge clk); #1;
      if (grant != '0) gcount++;
    end
    check("t5_gap_no_grant", gcount, 0);
    check("t5_idle_after_gap", busy, 0);
    req = 4'b0010;
    wait_grant(g, n);
    check("t5_grant_after_gap", g, 4'b0010);
    check("t5_grant_lat", n, 1);
    req = '0;
    wait_fd();

    // reset after byte 4, then a fresh frame
    do_reset();
    base = cap_q.size();
    req  = 4'b0001;
    wait_grant(g, n);
    req = '0;
    for (int k = 0; k < LIMIT && cap_q.size() < base + 4; k++) begin
      @(posedge clk); #1;
    end
    check("t6_four_bytes", cap_q.size() >= base + 4, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("t6_async");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = cap_q.size();
    req  = 4'b0001;
    wait_grant(g, n);
    check("t6_grant", g, 4'b0001);
    req = '0;
    wait_fd();
    check_frame("t6", base, 1'b0);

    check("start_while_busy", n_viol, 0);
    check("double_start", n_dbl, 0);
    check("tx_data_stable", n_stab, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
